// File: rtl/mine_placer_if.sv
// -----------------------------------------------------------------------------
// mine_placer_if
//   Board-side bus of the mine placer. It carries the shared Board read port
//   and the combined mine-write / adjacency-increment strobe.
//   Parameters : XW, YW      column / row coordinate widths
//   Signals    : readX, readY       shared Board read address
//                mineReadValue      mine Board read data (combinational)
//                placeEn            mine writeEn/writeValue + incAdjacent
//                placeX, placeY     mine/adjacency Board write address
//   Modports   : master (placer side), slave (Board side)
// -----------------------------------------------------------------------------
interface mine_placer_if #(
   parameter int XW = 3,
   parameter int YW = 3
);
   logic [XW-1:0] readX;
   logic [YW-1:0] readY;
   logic          mineReadValue;
   logic          placeEn;
   logic [XW-1:0] placeX;
   logic [YW-1:0] placeY;

   modport master (
      output readX, readY, placeEn, placeX, placeY,
      input  mineReadValue
   );

   modport slave (
      input  readX, readY, placeEn, placeX, placeY,
      output mineReadValue
   );
endinterface

// File: rtl/mine_placer.sv
// -----------------------------------------------------------------------------
// mine_placer
//   Game-setup sequencer. On start it places numMines distinct mines at
//   pseudo-random cells, driving the mine Board write port and the adjacency
//   Board increment strobe with one shared pulse, and shares the Board read
//   port between its own occupancy checks and the display scanner.
//
//   Parameters : width, height     board size (each >= 2)
//                numMines          mines placed per run
//                maxAttempts       rejected candidates allowed before abort
//                seed              LFSR reset value (nonzero)
//   Ports      : clk, reset        clock (rising), async active-high reset
//                start             begin a run (sampled only when idle)
//                dispX, dispY      display scanner read address
//                safeX, safeY      first-click cell (safe-zone build only)
//                board             mine_placer_if.master Board bus
//                busy              run in progress
//                done              one-cycle pulse at end of run
//                error             attempt limit hit, sticky until next start
//                minesPlaced       mines placed in current/last run
//
//   Build option: define MINE_PLACER_SAFE_ZONE_EN to exclude the 3x3 zone
//   around (safeX, safeY) from placement. Undefined, the whole board is
//   eligible and safeX/safeY are ignored.
// -----------------------------------------------------------------------------
module mine_placer #(
   parameter int          width       = 8,
   parameter int          height      = 8,
   parameter int          numMines    = 10,
   parameter int          maxAttempts = 1024,
   parameter logic [15:0] seed        = 16'hACE1,
   localparam int         XW          = $clog2(width),
   localparam int         YW          = $clog2(height),
   localparam int         MW          = $clog2(width * height + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [XW-1:0]  dispX,
   input  logic [YW-1:0]  dispY,
   input  logic [XW-1:0]  safeX,
   input  logic [YW-1:0]  safeY,
   mine_placer_if.master  board,
   output logic           busy,
   output logic           done,
   output logic           error,
   output logic [MW-1:0]  minesPlaced
);

   localparam int AW = $clog2(maxAttempts + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] PICK  = 3'd1;
   localparam logic [2:0] CHECK = 3'd2;
   localparam logic [2:0] PLACE = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]    state;
   logic [15:0]   lfsr;
   logic [XW-1:0] candX;
   logic [YW-1:0] candY;
   logic [XW-1:0] placeXq;
   logic [YW-1:0] placeYq;
   logic [AW-1:0] attempts;
   logic [AW-1:0] attemptsNext;
   logic [MW-1:0] minesNext;
   logic          outOfRange;
   logic          inZone;
   logic          reject;

   // ---------------------------------------------------------------------------
   // First-click exclusion zone
   // ---------------------------------------------------------------------------
`ifdef MINE_PLACER_SAFE_ZONE_EN
   logic [XW-1:0] safeXq;
   logic [YW-1:0] safeYq;

   // Safe cell is captured with the accepted start and held for the run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         safeXq <= '0;
         safeYq <= '0;
      end else if (state == IDLE && start) begin
         safeXq <= safeX;
         safeYq <= safeY;
      end
   end

   // |cand - safe| <= 1 on both axes; int arithmetic avoids wrap at the edges.
   assign inZone = (int'(candX) + 1 >= int'(safeXq)) && (int'(candX) <= int'(safeXq) + 1) &&
                   (int'(candY) + 1 >= int'(safeYq)) && (int'(candY) <= int'(safeYq) + 1);
`else
   logic unusedSafe;
   assign unusedSafe = ^{safeX, safeY};
   assign inZone     = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Candidate rejection
   // ---------------------------------------------------------------------------
   assign outOfRange   = (int'(candX) >= width) || (int'(candY) >= height);
   assign reject       = outOfRange || board.mineReadValue || inZone;
   assign attemptsNext = attempts + AW'(1);
   assign minesNext    = minesPlaced + MW'(1);

   // ---------------------------------------------------------------------------
   // Board bus: read port belongs to the scanner except while checking
   // ---------------------------------------------------------------------------
   assign board.readX   = (state == CHECK) ? candX : dispX;
   assign board.readY   = (state == CHECK) ? candY : dispY;
   assign board.placeEn = (state == PLACE);
   assign board.placeX  = placeXq;
   assign board.placeY  = placeYq;

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lfsr        <= seed;
         candX       <= '0;
         candY       <= '0;
         placeXq     <= '0;
         placeYq     <= '0;
         attempts    <= '0;
         minesPlaced <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         // Free-running Fibonacci LFSR, taps 16/14/13/11.
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         done <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state       <= PICK;
                  minesPlaced <= '0;
                  attempts    <= '0;
                  error       <= 1'b0;
                  busy        <= 1'b1;
               end
            end

            PICK: begin
               candX <= lfsr[XW-1:0];
               candY <= lfsr[XW+YW-1:XW];
               state <= CHECK;
            end

            CHECK: begin
               if (reject) begin
                  attempts <= attemptsNext;
                  if (attemptsNext == AW'(maxAttempts)) begin
                     error <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= PICK;
                  end
               end else begin
                  // Write address is loaded here so it is valid throughout PLACE.
                  placeXq <= candX;
                  placeYq <= candY;
                  state   <= PLACE;
               end
            end

            PLACE: begin
               minesPlaced <= minesNext;
               state       <= (minesNext == MW'(numMines)) ? DONE : PICK;
            end

            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
